// File: rtl/seq_pattern_scan_ctrl.sv
// Bit-serial 3-bit pattern scanner: accepts a word, scans it MSB first one bit
// per cycle, counts matches (overlapping or not), then presents the count.
module seq_pattern_scan_ctrl #(
   parameter int unsigned NBITS = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_val,
   output logic             in_rdy,
   input  logic [NBITS-1:0] in_msg,
   input  logic [2:0]       cfg_pattern,
   input  logic             cfg_overlap,
   output logic             out_val,
   input  logic             out_rdy,
   output logic [3:0]       out_msg,
   output logic             match
);

   localparam int unsigned IW = $clog2(NBITS);

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t           state_q, state_d;
   logic [NBITS-1:0] word_q, word_d;
   logic [2:0]       pat_q, pat_d;
   logic             ovl_q, ovl_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       hist_q, hist_d;
   logic [1:0]       fill_q, fill_d;
   logic [IW-1:0]    idx_q, idx_d;

   logic cur_bit;
   logic hit;

   assign cur_bit = word_q[idx_q];
   assign hit     = (fill_q == 2'd2) && ({hist_q, cur_bit} == pat_q);
   assign out_msg = cnt_q;

   // State and datapath registers; reset clears everything including latched config.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         pat_q   <= '0;
         ovl_q   <= 1'b0;
         cnt_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         pat_q   <= pat_d;
         ovl_q   <= ovl_d;
         cnt_q   <= cnt_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state, datapath updates and handshake outputs.
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      pat_d   = pat_q;
      ovl_d   = ovl_q;
      cnt_d   = cnt_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      idx_d   = idx_q;
      in_rdy  = 1'b0;
      out_val = 1'b0;
      match   = 1'b0;

      case (state_q)
         IDLE: begin
            in_rdy = 1'b1;
            if (in_val) begin
               word_d  = in_msg;
               pat_d   = cfg_pattern;
               ovl_d   = cfg_overlap;
               cnt_d   = '0;
               hist_d  = '0;
               fill_d  = '0;
               idx_d   = IW'(NBITS - 1);
               state_d = SCAN;
            end
         end
         SCAN: begin
            match  = hit;
            hist_d = {hist_q[0], cur_bit};
            cnt_d  = cnt_q + {3'b000, hit};
            // A non-overlapping match restarts the window so its bits are not reused.
            if (hit && !ovl_q) begin
               fill_d = '0;
            end else if (fill_q != 2'd2) begin
               fill_d = fill_q + 2'd1;
            end
            if (idx_q == '0) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q - IW'(1);
            end
         end
         DONE: begin
            out_val = 1'b1;
            if (out_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_seq_pattern_scan_ctrl.sv
// Directed and randomized checks of seq_pattern_scan_ctrl (NBITS=8) against a
// window-based reference model of the match rules.
module tb_seq_pattern_scan_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_val;
   logic       in_rdy;
   logic [7:0] in_msg;
   logic [2:0] cfg_pattern;
   logic       cfg_overlap;
   logic       out_val;
   logic       out_rdy;
   logic [3:0] out_msg;
   logic       match;

   int ncmp = 0;
   int nerr = 0;

   seq_pattern_scan_ctrl #(.NBITS(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_val      (in_val),
      .in_rdy      (in_rdy),
      .in_msg      (in_msg),
      .cfg_pattern (cfg_pattern),
      .cfg_overlap (cfg_overlap),
      .out_val     (out_val),
      .out_rdy     (out_rdy),
      .out_msg     (out_msg),
      .match       (match)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: bit k counted from the MSB completes a match when the three bits
   // k-2..k equal the pattern; without overlap a match needs 3 fresh bits after the previous one.
   function automatic void model(input logic [7:0] w, input logic [2:0] p, input logic ov,
                                 output logic [7:0] mask, output int cnt);
      int last;
      logic [2:0] win;
      last = -1;
      mask = '0;
      cnt  = 0;
      for (int k = 2; k < 8; k++) begin
         win = {w[9-k], w[8-k], w[7-k]};
         if (win == p && (ov || (k - last) >= 3)) begin
            mask[k] = 1'b1;
            cnt++;
            last = k;
         end
      end
   endfunction

   // Called at a negedge in IDLE. mode: 0 quiet inputs during the scan, 1 random
   // junk on inputs, 2 pattern forced to 000. rst_at >= 0 pulses reset at that bit.
   task automatic run_word(input logic [7:0] w, input logic [2:0] p, input logic ov,
                           input int hold, input int mode, input int rst_at);
      logic [7:0] mask;
      int         cnt;
      model(w, p, ov, mask, cnt);
      check("idle_in_rdy", 16'(in_rdy), 16'd1);
      check("idle_out_val", 16'(out_val), 16'd0);
      in_val      = 1'b1;
      in_msg      = w;
      cfg_pattern = p;
      cfg_overlap = ov;
      @(posedge clk);
      @(negedge clk);
      in_val = 1'b0;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("scan_match_b%0d", k), 16'(match), 16'(mask[k]));
         check("scan_in_rdy", 16'(in_rdy), 16'd0);
         check("scan_out_val", 16'(out_val), 16'd0);
         if (k == rst_at) begin
            reset  = 1'b0;
            in_val = 1'b0;
            #1;
            check("rst_in_rdy", 16'(in_rdy), 16'd1);
            check("rst_out_val", 16'(out_val), 16'd0);
            check("rst_out_msg", 16'(out_msg), 16'd0);
            check("rst_match", 16'(match), 16'd0);
            #2;
            reset = 1'b1;
            return;
         end
         if (mode == 1) begin
            in_msg      = 8'($urandom);
            cfg_pattern = 3'($urandom);
            cfg_overlap = 1'($urandom);
            in_val      = 1'($urandom);
         end else if (mode == 2) begin
            cfg_pattern = 3'b000;
         end
         @(negedge clk);
      end
      if (mode != 0) in_val = 1'b1;
      out_rdy = 1'b0;
      for (int h = 0; h <= hold; h++) begin
         check("done_out_val", 16'(out_val), 16'd1);
         check("done_out_msg", 16'(out_msg), 16'(cnt));
         check("done_in_rdy", 16'(in_rdy), 16'd0);
         check("done_match", 16'(match), 16'd0);
         if (h == hold) out_rdy = 1'b1;
         @(negedge clk);
      end
      out_rdy = 1'b0;
      in_val  = 1'b0;
      check("ret_in_rdy", 16'(in_rdy), 16'd1);
      check("ret_out_val", 16'(out_val), 16'd0);
   endtask

   initial begin
      reset       = 1'b0;
      in_val      = 1'b0;
      in_msg      = '0;
      cfg_pattern = '0;
      cfg_overlap = 1'b0;
      out_rdy     = 1'b0;
      #1;
      check("reset_in_rdy", 16'(in_rdy), 16'd1);
      check("reset_out_val", 16'(out_val), 16'd0);
      check("reset_out_msg", 16'(out_msg), 16'd0);
      check("reset_match", 16'(match), 16'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      run_word(8'b10101010, 3'b101, 1'b1, 0, 0, -1);
      run_word(8'b10101010, 3'b101, 1'b0, 0, 0, -1);
      run_word(8'hFF, 3'b111, 1'b1, 0, 0, -1);
      run_word(8'hFF, 3'b111, 1'b0, 0, 0, -1);
      run_word(8'h00, 3'b111, 1'b1, 0, 0, -1);
      run_word(8'b10101010, 3'b101, 1'b1, 5, 1, -1);
      run_word(8'b10101010, 3'b101, 1'b1, 0, 0, 4);
      run_word(8'b10101010, 3'b101, 1'b1, 0, 0, -1);
      run_word(8'b10101010, 3'b101, 1'b1, 1, 2, -1);

      for (int i = 0; i < 40; i++) begin
         run_word(8'($urandom), 3'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
